isdu_fetch_ctrl: RTL and testbench

- Moore control FSM directly upstream of the datapath; drives all of the datapath's load, gate and mux select inputs plus the memory enables.
- Runs the LC-3 fetch/decode loop:
  - MAR<-PC and PC<-PC+1;
  - memory read into MDR with a configurable number of wait cycles;
  - IR<-MDR;
  - decode.
- Implements the PAUSE instruction (LED display, waits for Continue). Every other opcode retires as a NOP in this block.

---
 rtl/isdu_pkg.sv | 27 ++
 rtl/mem_wait_counter.sv | 37 +++
 rtl/isdu_fetch_ctrl.sv | 144 ++++++++++++++
 tb/tb_isdu_fetch_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/isdu_pkg.sv
// Shared types and constants for the ISDU control path: state encoding,
// opcode values and PC mux selects.
package isdu_pkg;

    // Encodings are visible on the State debug output, so they are fixed.
    typedef enum logic [3:0] {
        HALTED  = 4'd0,
        S_18    = 4'd1,
        S_33    = 4'd2,
        S_35    = 4'd3,
        S_32    = 4'd4,
        PAUSE_1 = 4'd5,
        PAUSE_2 = 4'd6
    } state_t;

    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    // True when the opcode field selects the PAUSE instruction.
    function automatic logic is_pause(input logic [3:0] opcode);
        return opcode == OP_PAUSE;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter used to time memory accesses. Loaded with (wait-1) when an
// access is launched, decremented while the access is in progress; done_o
// marks the final cycle of the access.
module mem_wait_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] value_i,
    input  logic       dec_i,
    output logic       done_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Load takes priority over decrement; the count saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 4'd0);

endmodule

// File: rtl/isdu_fetch_ctrl.sv
// Moore control FSM for the LC-3 fetch/decode loop. Drives the datapath
// loads, bus gates, mux selects and memory enables. PAUSE shows IR on the
// LEDs until Continue is pressed and released; all other opcodes retire as
// NOPs and the loop returns to fetch.
module isdu_fetch_ctrl
    import isdu_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_MDR,
    output logic        LD_MAR,
    output logic        LD_IR,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic        MIO_EN,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [3:0]  State
);

    // The counter holds "cycles remaining after this one", so the memory
    // state lasts exactly MEM_WAIT cycles.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t state_q;
    state_t state_d;

    logic wait_load;
    logic wait_dec;
    logic wait_done;

    // Only the opcode field matters here; the rest of IR feeds execute states.
    logic unused_ir;
    assign unused_ir = ^IR[11:0];

    mem_wait_counter u_wait (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .load_i  (wait_load),
        .value_i (WAIT_LOAD),
        .dec_i   (wait_dec),
        .done_o  (wait_done)
    );

    // State register; reset forces HALTED regardless of any other input.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore output decode from the current state.
    always_comb begin
        state_d    = state_q;
        wait_load  = 1'b0;
        wait_dec   = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_MDR     = 1'b0;
        LD_MAR     = 1'b0;
        LD_IR      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_PC1;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;

        case (state_q)
            HALTED: begin
                if (Run) begin
                    state_d = S_18;
                end
            end
            S_18: begin
                GatePC    = 1'b1;
                LD_MAR    = 1'b1;
                LD_PC     = 1'b1;
                PCMUX     = PCMUX_PC1;
                wait_load = 1'b1;
                state_d   = S_33;
            end
            S_33: begin
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                if (wait_done) begin
                    LD_MDR  = 1'b1;
                    state_d = S_35;
                end else begin
                    wait_dec = 1'b1;
                end
            end
            S_35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                state_d = S_32;
            end
            S_32: begin
                if (is_pause(IR[15:12])) begin
                    state_d = PAUSE_1;
                end else begin
                    state_d = S_18;
                end
            end
            // LD_LED is held in both pause states: the LED register clears
            // whenever the load drops.
            PAUSE_1: begin
                LD_LED = 1'b1;
                if (Continue) begin
                    state_d = PAUSE_2;
                end
            end
            // Waiting for release so one press advances exactly one PAUSE.
            PAUSE_2: begin
                LD_LED = 1'b1;
                if (!Continue) begin
                    state_d = S_18;
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_isdu_fetch_ctrl.sv
// Bench for isdu_fetch_ctrl: four copies with different MEM_WAIT values share
// one input stream; each is compared every cycle against a model that tracks
// where the block is inside an instruction (cycle offset since S_18).
module tb_isdu_fetch_ctrl;

    localparam int NDUT = 4;

    function automatic int mw_of(input int i);
        case (i)
            0:       return 2;
            1:       return 4;
            2:       return 1;
            default: return 15;
        endcase
    endfunction

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_r;
    logic        run_r;
    logic        cont_r;
    logic [15:0] ir_r;

    wire [NDUT-1:0] ld_reg_w, ld_pc_w, ld_mdr_w, ld_mar_w, ld_ir_w, ld_led_w;
    wire [NDUT-1:0] gate_pc_w, gate_mdr_w, gate_alu_w, gate_marmux_w;
    wire [NDUT-1:0] mio_en_w, mem_oe_w, mem_we_w;
    wire [1:0]      pcmux_w [NDUT];
    wire [3:0]      state_w [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        isdu_fetch_ctrl #(.MEM_WAIT(mw_of(g))) u_dut (
            .Clk        (clk),
            .Reset      (reset_r),
            .Run        (run_r),
            .Continue   (cont_r),
            .IR         (ir_r),
            .LD_REG     (ld_reg_w[g]),
            .LD_PC      (ld_pc_w[g]),
            .LD_MDR     (ld_mdr_w[g]),
            .LD_MAR     (ld_mar_w[g]),
            .LD_IR      (ld_ir_w[g]),
            .LD_LED     (ld_led_w[g]),
            .GatePC     (gate_pc_w[g]),
            .GateMDR    (gate_mdr_w[g]),
            .GateALU    (gate_alu_w[g]),
            .GateMARMUX (gate_marmux_w[g]),
            .PCMUX      (pcmux_w[g]),
            .MIO_EN     (mio_en_w[g]),
            .Mem_OE     (mem_oe_w[g]),
            .Mem_WE     (mem_we_w[g]),
            .State      (state_w[g])
        );
    end

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int errors  = 0;

    task automatic check_eq(input string tag, input logic [18:0] act, input logic [18:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 halted, 1 in an instruction, 2 paused awaiting press,
    // 3 paused awaiting release. pos: cycles since the S_18 of this
    // instruction (0 = S_18, 1..mw = memory read, mw+1 = IR load, mw+2 = decode).
    int m_mode [NDUT];
    int m_pos  [NDUT];
    logic [18:0] exp_q[$];

    // Output vector order: State, six loads, four gates, PCMUX, MIO_EN, Mem_OE, Mem_WE.
    function automatic logic [18:0] pack(input logic [3:0] st, input logic [5:0] lds,
                                         input logic [3:0] gates, input logic [1:0] pcm,
                                         input logic mio, input logic oe, input logic we);
        return {st, lds, gates, pcm, mio, oe, we};
    endfunction

    function automatic logic [18:0] model_out(input int mode, input int pos, input int mw);
        // lds = {LD_REG, LD_PC, LD_MDR, LD_MAR, LD_IR, LD_LED}
        // gates = {GatePC, GateMDR, GateALU, GateMARMUX}
        if (mode == 2) return pack(4'd5, 6'b000001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1);
        if (mode == 3) return pack(4'd6, 6'b000001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1);
        if (mode == 1) begin
            if (pos == 0)
                return pack(4'd1, 6'b010100, 4'b1000, 2'b00, 1'b0, 1'b1, 1'b1);
            if (pos >= 1 && pos <= mw)
                return pack(4'd2, (pos == mw) ? 6'b001000 : 6'b000000, 4'b0000, 2'b00,
                            1'b1, 1'b0, 1'b1);
            if (pos == mw + 1)
                return pack(4'd3, 6'b000010, 4'b0100, 2'b00, 1'b0, 1'b1, 1'b1);
            return pack(4'd4, 6'b000000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1);
        end
        return pack(4'd0, 6'b000000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1);
    endfunction

    function automatic logic [18:0] observed(input int i);
        return pack(state_w[i],
                    {ld_reg_w[i], ld_pc_w[i], ld_mdr_w[i], ld_mar_w[i], ld_ir_w[i], ld_led_w[i]},
                    {gate_pc_w[i], gate_mdr_w[i], gate_alu_w[i], gate_marmux_w[i]},
                    pcmux_w[i], mio_en_w[i], mem_oe_w[i], mem_we_w[i]);
    endfunction

    // Advance the model by one clock edge given the inputs sampled at that edge.
    task automatic model_step(input logic rst, input logic run, input logic cont,
                              input logic [15:0] ir);
        for (int i = 0; i < NDUT; i++) begin
            int mw;
            mw = mw_of(i);
            if (rst) begin
                m_mode[i] = 0;
                m_pos[i]  = 0;
            end else begin
                case (m_mode[i])
                    0: if (run) begin m_mode[i] = 1; m_pos[i] = 0; end
                    1: begin
                        if (m_pos[i] < mw + 2) m_pos[i] = m_pos[i] + 1;
                        else if (ir[15:12] == 4'hD) m_mode[i] = 2;
                        else m_pos[i] = 0;
                    end
                    2: if (cont) m_mode[i] = 3;
                    3: if (!cont) begin m_mode[i] = 1; m_pos[i] = 0; end
                    default: m_mode[i] = 0;
                endcase
            end
        end
    endtask

    // ---------------- driver ----------------
    bit checking = 0;

    // At each falling edge: compare all copies, then drive the next inputs.
    task automatic step(input logic rst, input logic run, input logic cont,
                        input logic [15:0] ir);
        @(negedge clk);
        if (checking) begin
            for (int i = 0; i < NDUT; i++) exp_q.push_back(model_out(m_mode[i], m_pos[i], mw_of(i)));
            for (int i = 0; i < NDUT; i++) begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check_eq($sformatf("outputs_mw%0d", mw_of(i)), observed(i), e);
            end
        end
        reset_r = rst;
        run_r   = run;
        cont_r  = cont;
        ir_r    = ir;
        model_step(rst, run, cont, ir);
        checking = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_r = 1'b1;
        run_r   = 1'b0;
        cont_r  = 1'b0;
        ir_r    = 16'h0000;
        for (int i = 0; i < NDUT; i++) begin m_mode[i] = 0; m_pos[i] = 0; end

        // Reset for 3 cycles, then idle with Run low.
        repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (10) step(1'b0, 1'b0, 1'b0, 16'h0000);

        // One-cycle Run pulse, NOP loop, then Run toggled (must be ignored).
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        repeat (12) step(1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (6) step(1'b0, 1'b1, 1'b0, 16'h0000);

        // PAUSE reaches every copy; press for 4 cycles, then release.
        repeat (25) step(1'b0, 1'b0, 1'b0, 16'hD3FF);
        repeat (4) step(1'b0, 1'b0, 1'b1, 16'hD3FF);
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000);

        // Continue held during NOP fetches has no effect.
        repeat (40) step(1'b0, 1'b0, 1'b1, 16'h1234);

        // Reset landing on the first memory-read cycle.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (4) step(1'b0, 1'b0, 1'b0, 16'h0000);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ir;
            ir = 16'($urandom);
            if ($urandom_range(0, 2) == 0) ir[15:12] = 4'hD;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0), ir);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
